// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine credit path.
package vend_pkg;

  localparam int CENT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    VEND  = 2'd2,
    DENY  = 2'd3
  } vend_state_t;

  localparam logic [CENT_W-1:0] QUARTER_C = 7'd25;
  localparam logic [CENT_W-1:0] DIME_C    = 7'd10;
  localparam logic [CENT_W-1:0] NICKEL_C  = 7'd5;

  // Value of the winning coin when several edges coincide (quarter > dime > nickel).
  function automatic logic [CENT_W-1:0] coin_pick(input logic q, input logic d, input logic n);
    logic [CENT_W-1:0] v;
    if (q) begin
      v = QUARTER_C;
    end else if (d) begin
      v = DIME_C;
    end else if (n) begin
      v = NICKEL_C;
    end else begin
      v = 7'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Optional two-flop synchronizer (SYNC_EN) followed by a rising-edge pulse generator.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic w_level;
  logic r_prev;

`ifdef SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_level};
    end
  end

  assign w_level = r_sync[1];
`else
  assign w_level = i_level;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/coin_credit_acc.sv
// Coin/purchase credit accumulators and buy/vend handshake.
// Define SYNC_EN to insert two-flop synchronizers ahead of the button edge detectors.
module coin_credit_acc
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT  = 100,
  parameter int VEND_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin_q,
  input  logic              coin_d,
  input  logic              coin_n,
  input  logic              buy,
  input  logic              cancel,
  input  logic [CENT_W-1:0] price,
  output logic [CENT_W-1:0] q_cred,
  output logic [CENT_W-1:0] d_cred,
  output logic [CENT_W-1:0] n_cred,
  output logic [CENT_W-1:0] debt,
  output logic [CENT_W-1:0] credit,
  output logic              vend,
  output logic              denied,
  output logic              reject
);

  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  logic w_q_edge, w_d_edge, w_n_edge, w_buy_edge, w_cancel_edge;
  logic w_any_coin, w_multi_coin, w_fits;
  logic [CENT_W-1:0] w_coin_val, w_credit;
  logic [CENT_W:0]   w_after_coin;

  vend_state_t       r_state;
  logic [CENT_W-1:0] r_q, r_d, r_n, r_debt, r_price;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_vend, r_denied, r_reject;

  edge_det u_ed_q      (.clk(clk), .reset(reset), .i_level(coin_q), .o_rise(w_q_edge));
  edge_det u_ed_d      (.clk(clk), .reset(reset), .i_level(coin_d), .o_rise(w_d_edge));
  edge_det u_ed_n      (.clk(clk), .reset(reset), .i_level(coin_n), .o_rise(w_n_edge));
  edge_det u_ed_buy    (.clk(clk), .reset(reset), .i_level(buy),    .o_rise(w_buy_edge));
  edge_det u_ed_cancel (.clk(clk), .reset(reset), .i_level(cancel), .o_rise(w_cancel_edge));

  // Net credit wraps mod 128 exactly like the downstream summing stage.
  assign w_credit     = r_q + r_d + r_n + r_debt;
  assign w_any_coin   = w_q_edge | w_d_edge | w_n_edge;
  assign w_multi_coin = (w_q_edge & w_d_edge) | (w_q_edge & w_n_edge) | (w_d_edge & w_n_edge);
  assign w_coin_val   = coin_pick(w_q_edge, w_d_edge, w_n_edge);
  assign w_after_coin = {1'b0, w_credit} + {1'b0, w_coin_val};
  assign w_fits       = (w_after_coin <= (CENT_W+1)'(MAX_CREDIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= 7'd0;
      r_d      <= 7'd0;
      r_n      <= 7'd0;
      r_debt   <= 7'd0;
      r_price  <= 7'd0;
      r_cnt    <= '0;
      r_vend   <= 1'b0;
      r_denied <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_denied <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        IDLE: begin
          r_vend <= 1'b0;
          if (w_cancel_edge) begin
            r_q      <= 7'd0;
            r_d      <= 7'd0;
            r_n      <= 7'd0;
            r_debt   <= 7'd0;
            r_reject <= w_any_coin;
          end else begin
            if (w_any_coin) begin
              if (w_fits) begin
                if (w_q_edge) begin
                  r_q <= r_q + w_coin_val;
                end else if (w_d_edge) begin
                  r_d <= r_d + w_coin_val;
                end else begin
                  r_n <= r_n + w_coin_val;
                end
              end
              r_reject <= w_multi_coin | ~w_fits;
            end
            // Coin above lands in the same edge, so CHECK sees the updated credit.
            if (w_buy_edge) begin
              r_price <= price;
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          r_reject <= w_any_coin;
          if (w_credit >= r_price) begin
            r_debt  <= r_debt - r_price;
            r_vend  <= 1'b1;
            r_cnt   <= CNT_W'(VEND_CYCLES - 1);
            r_state <= VEND;
          end else begin
            r_denied <= 1'b1;
            r_state  <= DENY;
          end
        end
        VEND: begin
          r_reject <= w_any_coin;
          if (r_cnt == '0) begin
            r_vend  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DENY: begin
          r_reject <= w_any_coin;
          r_state  <= IDLE;
        end
        default: begin
          r_vend  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign q_cred = r_q;
  assign d_cred = r_d;
  assign n_cred = r_n;
  assign debt   = r_debt;
  assign credit = w_credit;
  assign vend   = r_vend;
  assign denied = r_denied;
  assign reject = r_reject;

endmodule
